// File: rtl/output_fader.sv
// Ramped-gain fader between the mixer and the PDM DACs: glides power-up, mute and unmute
// transitions by stepping the gain one LSB at a time, paced by the sample strobe.
module output_fader #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned GAIN_BITS = 8,
  parameter int unsigned RAMP_DIV  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_clk,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 mute,
  input  logic [GAIN_BITS:0]   target_gain,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 muted
);

  localparam int unsigned CntW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned ProdW = DATA_BITS + GAIN_BITS + 2;

  localparam logic [DATA_BITS-1:0] Mid     = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [GAIN_BITS:0]   Unity   = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GAIN_BITS:0]   GainOne = {{GAIN_BITS{1'b0}}, 1'b1};
  localparam logic [CntW-1:0]      CntOne  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0]      CntLast = CntW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {StMuted, StTrack, StPlay, StRampDown} state_e;

  state_e                state_q, state_d;
  logic [GAIN_BITS:0]    gain_q, gain_d;
  logic [CntW-1:0]       ramp_cnt_q, ramp_cnt_d;
  logic                  sclk_q;
  logic                  strobe;
  logic                  step_en;
  logic [GAIN_BITS:0]    tgt_c;

  logic signed [DATA_BITS:0] x_q, x_d;
  logic [GAIN_BITS:0]        g_q;
  logic signed [ProdW-1:0]   x_ext, g_ext, p_q, p_d, p_shr;
  logic                      v1_q, v2_q;
  logic [DATA_BITS-1:0]      dout_d;

  assign tgt_c   = (target_gain > Unity) ? Unity : target_gain;
  assign strobe  = sample_clk & ~sclk_q;
  assign step_en = strobe && (ramp_cnt_q == CntLast);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StMuted;
      gain_q     <= '0;
      ramp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      ramp_cnt_q <= ramp_cnt_d;
    end
  end

  // FSM: next state; the tgt_c==0 && gain==0 exit is tested before gain==tgt_c so it is reachable
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StMuted: begin
        if (!mute && tgt_c != '0) state_d = StTrack;
      end
      StTrack: begin
        if (mute)                               state_d = StRampDown;
        else if (tgt_c == '0 && gain_q == '0)   state_d = StMuted;
        else if (gain_q == tgt_c)               state_d = StPlay;
      end
      StPlay: begin
        if (mute)                 state_d = StRampDown;
        else if (tgt_c != gain_q) state_d = StTrack;
      end
      StRampDown: begin
        if (gain_q == '0) state_d = StMuted;
        else if (!mute)   state_d = StTrack;
      end
      default: state_d = StMuted;
    endcase
  end

  // Gain stepping and ramp pacing; the sample captured on this strobe still sees gain_q
  always_comb begin
    gain_d     = gain_q;
    ramp_cnt_d = ramp_cnt_q;
    if (strobe) begin
      if (step_en) begin
        ramp_cnt_d = '0;
        unique case (state_q)
          StTrack: begin
            if (gain_q < tgt_c)      gain_d = gain_q + GainOne;
            else if (gain_q > tgt_c) gain_d = gain_q - GainOne;
          end
          StRampDown: begin
            if (gain_q != '0) gain_d = gain_q - GainOne;
          end
          StMuted: gain_d = '0;
          default: gain_d = gain_q;
        endcase
      end else begin
        ramp_cnt_d = ramp_cnt_q + CntOne;
      end
    end
    if (state_d != state_q) ramp_cnt_d = '0;
  end

  // FSM: outputs
  always_comb begin
    muted = (state_q == StMuted);
  end

  assign x_d    = $signed({1'b0, din}) - $signed({1'b0, Mid});
  assign x_ext  = {{(ProdW-DATA_BITS-1){x_q[DATA_BITS]}}, x_q};
  assign g_ext  = {{(ProdW-GAIN_BITS-1){1'b0}}, g_q};
  assign p_d    = x_ext * g_ext;
  // Arithmetic shift floors toward minus infinity; |gain| <= unity keeps the sum in range
  assign p_shr  = p_q >>> GAIN_BITS;
  assign dout_d = Mid + p_shr[DATA_BITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q     <= 1'b0;
      x_q        <= '0;
      g_q        <= '0;
      p_q        <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      dout       <= Mid;
      dout_valid <= 1'b0;
    end else begin
      sclk_q     <= sample_clk;
      v1_q       <= strobe;
      v2_q       <= v1_q;
      dout_valid <= v2_q;
      if (strobe) begin
        x_q <= x_d;
        g_q <= gain_q;
      end
      if (v1_q) p_q <= p_d;
      if (v2_q) dout <= dout_d;
    end
  end

endmodule

// File: tb/tb_output_fader.sv
// Bench for output_fader: two instances (RAMP_DIV 1 and 4) share randomized stimulus; a
// behavioural model queues expected samples and a negedge monitor checks each dout_valid.
module tb_output_fader;

  localparam int MdMuted = 0;
  localparam int MdTrack = 1;
  localparam int MdPlay  = 2;
  localparam int MdDown  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_clk = 1'b0;
  logic [11:0] din = 12'd4095;
  logic        mute = 1'b1;
  logic [8:0]  target_gain = 9'd0;
  logic [11:0] dout_w [2];
  logic        valid_w [2];
  logic        muted_w [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int din_fix = -1;

  int rdiv [2] = '{1, 4};
  int mode [2] = '{MdMuted, MdMuted};
  int gain [2] = '{0, 0};
  int cnt  [2] = '{0, 0};
  int prev [2] = '{0, 0};
  int exp_v [2][$];
  int exp_t [2][$];

  output_fader #(.DATA_BITS(12), .GAIN_BITS(8), .RAMP_DIV(1)) u_fast (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .din(din), .mute(mute),
    .target_gain(target_gain), .dout(dout_w[0]), .dout_valid(valid_w[0]), .muted(muted_w[0])
  );

  output_fader #(.DATA_BITS(12), .GAIN_BITS(8), .RAMP_DIV(4)) u_slow (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .din(din), .mute(mute),
    .target_gain(target_gain), .dout(dout_w[1]), .dout_valid(valid_w[1]), .muted(muted_w[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0d expected=%0d", nm, k, cyc, act, exp);
    end
  endtask

  // Reference: expected output is midscale plus floor((din-mid)*gain/256)
  task automatic model_step(input int k);
    int tgt, nxt, num, q;
    bit strobe;
    if (rst) begin
      mode[k] = MdMuted; gain[k] = 0; cnt[k] = 0; prev[k] = 0;
      exp_v[k].delete(); exp_t[k].delete();
      return;
    end
    strobe  = sample_clk && (prev[k] == 0);
    prev[k] = int'(sample_clk);
    tgt = (int'(target_gain) > 256) ? 256 : int'(target_gain);
    if (strobe) begin
      num = (int'(din) - 2048) * gain[k];
      q   = num / 256;
      if (num < 0 && (num % 256) != 0) q = q - 1;
      exp_v[k].push_back(2048 + q);
      exp_t[k].push_back(cyc + 2);
    end
    nxt = mode[k];
    case (mode[k])
      MdMuted: if (!mute && tgt != 0) nxt = MdTrack;
      MdTrack: begin
        if (mute) nxt = MdDown;
        else if (tgt == 0 && gain[k] == 0) nxt = MdMuted;
        else if (gain[k] == tgt) nxt = MdPlay;
      end
      MdPlay: begin
        if (mute) nxt = MdDown;
        else if (tgt != gain[k]) nxt = MdTrack;
      end
      default: begin
        if (gain[k] == 0) nxt = MdMuted;
        else if (!mute) nxt = MdTrack;
      end
    endcase
    if (strobe) begin
      if (cnt[k] == rdiv[k] - 1) begin
        cnt[k] = 0;
        if (mode[k] == MdTrack) begin
          if (tgt > gain[k]) gain[k]++;
          else if (tgt < gain[k]) gain[k]--;
        end else if (mode[k] == MdDown && gain[k] > 0) begin
          gain[k]--;
        end
      end else begin
        cnt[k]++;
      end
    end
    if (nxt != mode[k]) cnt[k] = 0;
    mode[k] = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
    end
  end

  // Monitor: pop one expectation per dout_valid; an overdue expectation is a missing sample
  initial begin
    int ev, et;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (valid_w[k] === 1'b1) begin
          if (exp_v[k].size() == 0) begin
            check("unexpected_valid", k, 1, 0);
          end else begin
            ev = exp_v[k].pop_front();
            et = exp_t[k].pop_front();
            check("dout", k, int'(dout_w[k]), ev);
            check("latency", k, cyc, et);
          end
        end else if (exp_t[k].size() > 0 && cyc > exp_t[k][0]) begin
          check("missing_valid", k, cyc, exp_t[k][0]);
          void'(exp_v[k].pop_front());
          void'(exp_t[k].pop_front());
        end
        check("muted", k, int'(muted_w[k]), (mode[k] == MdMuted) ? 1 : 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) begin
      din = (din_fix >= 0) ? 12'(din_fix) : 12'($urandom);
      sample_clk = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      sample_clk = 1'b0;
      repeat ($urandom_range(2, 3)) tick();
    end
  endtask

  task automatic idle_reset();
    sample_clk = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("reset_dout", k, int'(dout_w[k]), 2048);
      check("reset_muted", k, int'(muted_w[k]), 1);
      check("reset_valid", k, int'(valid_w[k]), 0);
    end
    repeat (4) tick();
  endtask

  initial begin
    // Reset with the sample clock toggling and full-scale input
    #1;
    sample_clk = 1'b1; tick();
    sample_clk = 1'b0; tick();
    sample_clk = 1'b1; tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("post_reset_dout", k, int'(dout_w[k]), 2048);
      check("post_reset_muted", k, int'(muted_w[k]), 1);
    end
    sample_clk = 1'b0; tick(); tick();
    din_fix = 4095;
    samples(5);

    // Unmute ramp to unity, then full-scale negative input
    target_gain = 9'd256; mute = 1'b0; din_fix = -1;
    samples(300);
    din_fix = 0;
    samples(6);

    // Long high time on sample_clk must give a single strobe
    din = 12'd4095;
    sample_clk = 1'b1; repeat (50) tick();
    sample_clk = 1'b0; repeat (5) tick();

    // Half gain, then minimum gain with floor rounding
    target_gain = 9'd128; din_fix = -1;
    samples(140);
    din_fix = 0;
    samples(6);
    target_gain = 9'd1; din_fix = -1;
    samples(140);
    din_fix = 1;
    samples(6);

    // Mute mid-ramp, unmute partway down, then mute fully
    din_fix = -1; target_gain = 9'd100;
    samples(120);
    mute = 1'b1;  samples(60);
    mute = 1'b0;  samples(80);
    mute = 1'b1;  samples(120);

    // Target above unity clamps; then reset partway down a ramp
    mute = 1'b0; target_gain = 9'd300;
    samples(300);
    mute = 1'b1;
    samples(179);
    idle_reset();

    // Random targets and mute toggling
    for (int i = 0; i < 30; i++) begin
      target_gain = 9'($urandom_range(0, 300));
      mute = ($urandom_range(0, 3) == 0);
      samples($urandom_range(5, 40));
    end

    sample_clk = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 2; k++) check("drain", k, exp_v[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_fader.md
Name: output_fader

Overview:
- Sits between song_player's audio_out and the pdm_dac instances in the top level.
- Applies a ramped gain to the 12-bit unsigned mix so that power-up, mute and unmute transitions glide instead of clicking.
- Gain ramps one LSB at a time, paced by the sample clock, toward a target level or toward zero when muted.
- Output is a registered sample plus a one-cycle valid pulse for each sample period.

Parameters:
- DATA_BITS, 12: width of din/dout, unsigned offset-binary; midscale 2^(DATA_BITS-1) is silence.
- GAIN_BITS, 8: gain fraction bits; unity gain = 2^GAIN_BITS.
- RAMP_DIV, 16: sample strobes per one-LSB gain step (≥1).

Ports:
- clk, input, 1: single clock for all logic (16 MHz CLK).
- rst, input, 1: synchronous, active-high reset.
- sample_clk, input, 1: sample-rate square wave from clock_divider, synchronous to clk; rising edge = one sample.
- din, input, DATA_BITS: unsigned mix sample from song_player.
- mute, input, 1: level; 1 ramps the gain down to 0.
- target_gain, input, GAIN_BITS+1: desired gain; values above 2^GAIN_BITS clamp to 2^GAIN_BITS (tgt_c).
- dout, output, DATA_BITS: faded sample to pdm_dac.
- dout_valid, output, 1: one-cycle pulse when dout updates.
- muted, output, 1: high while the state is MUTED.

Behaviour:
- Reset (synchronous, any time including mid-ramp):
  - State = MUTED, gain = 0, ramp counter = 0.
  - dout = 2^(DATA_BITS-1), dout_valid = 0, muted = 1.
  - Edge-detect register = 0, pipeline registers cleared.
- Strobe:
  - s_d registers sample_clk every cycle.
  - strobe = sample_clk & ~s_d, so there is exactly one strobe per rising edge regardless of high time.
- Datapath, 2-stage pipeline:
  - Edge N (strobe true): capture x = din − 2^(DATA_BITS−1) as signed (DATA_BITS+1) bits, and capture the current gain.
  - Edge N+1: p = x × gain, signed, DATA_BITS+GAIN_BITS+2 bits.
  - Edge N+2: dout = 2^(DATA_BITS−1) + (p >>> GAIN_BITS). The shift is arithmetic, so the result is floored.
  - dout_valid is high for the single cycle after edge N+2.
  - |gain| ≤ unity, so no clamp is needed; the result is always in range.
  - Strobes at least 3 cycles apart are supported; closer strobes are out of spec.
- Gain stepping:
  - Acts only on strobe cycles.
  - On a strobe, if ramp_cnt == RAMP_DIV−1: apply the state's step and set ramp_cnt = 0; otherwise ramp_cnt += 1.
  - The sample captured on that strobe uses the pre-step gain.
  - ramp_cnt resets to 0 on every state change.
- State machine (transitions evaluated every cycle):
  - MUTED: gain held at 0. Go to TRACK if !mute and tgt_c ≠ 0.
  - TRACK: step gain ±1 toward tgt_c.
    - mute → RAMP_DOWN (priority).
    - gain == tgt_c → PLAY.
    - tgt_c == 0 and gain == 0 → MUTED.
  - PLAY: gain held.
    - mute → RAMP_DOWN.
    - tgt_c ≠ gain → TRACK.
  - RAMP_DOWN: step gain −1.
    - gain == 0 → MUTED.
    - !mute (while gain > 0) → TRACK.
- Simultaneous events:
  - mute asserted on the same cycle gain reaches tgt_c → RAMP_DOWN, not PLAY.
  - Any step that would cross the bound saturates at tgt_c (TRACK) or 0 (RAMP_DOWN).
- Timing at defaults:
  - Full ramp 0 → 256 = 256 × 16 = 4096 samples ≈ 93 ms at 44.1 kHz.
  - Samples keep flowing in every state; in MUTED dout = midscale.

Test Plan:
1. Reset: hold rst 3 cycles with din = 4095 and sample_clk toggling → dout = 2048, muted = 1, dout_valid pulses each sample with dout = 2048 (gain 0).
2. Latency and strobe: RAMP_DIV = 1, gain preset to 256 via unmute ramp, din = 4095, sample_clk held high 50 cycles → exactly one dout_valid, 2 cycles after the detection edge, dout = 4095.
3. Unmute ramp: RAMP_DIV = 1, target = 256, mute = 0 → muted falls the cycle after entering TRACK; after 256 strobes state = PLAY, gain = 256; din = 0 gives dout = 0.
4. Arithmetic: gain held 128, din = 0 → dout = 1024. Gain 1, din = 1 → dout = 2040 (floor of −2047/256 = −8).
5. Mute mid-ramp: RAMP_DIV = 1, ramp up to gain 100, assert mute → gain decreases by 1 per strobe, reaching 0 after 100 strobes; muted = 1 and dout = 2048 thereafter. Deassert mute at gain 40 → returns to TRACK and climbs.
6. Clamp and reset: target_gain = 300 → gain stops at 256 in PLAY. Assert rst mid-ramp at gain 77 → next cycle gain = 0, MUTED, dout = 2048, no dout_valid until a new strobe.
